// File: rtl/gesture_pkg.sv
// Shared types and constants for the PWM-to-gesture encoder: gesture codes, finger indices
// and the pattern-to-code map.
package gesture_pkg;

  localparam int unsigned NUM_FINGERS = 5;
  localparam int unsigned WIDTH_W     = 16;
  localparam int unsigned GEST_W      = 8;

  typedef logic [WIDTH_W-1:0] width_us_t;
  typedef logic [GEST_W-1:0]  gesture_t;

  localparam int unsigned FINGER_THUMB  = 0;
  localparam int unsigned FINGER_INDEX  = 1;
  localparam int unsigned FINGER_MIDDLE = 2;
  localparam int unsigned FINGER_RING   = 3;
  localparam int unsigned FINGER_PINKY  = 4;

  localparam gesture_t GEST_NONE          = 8'd0;
  localparam gesture_t GEST_ROCK          = 8'd1;
  localparam gesture_t GEST_PAPER         = 8'd2;
  localparam gesture_t GEST_SCISSORS      = 8'd3;
  localparam gesture_t GEST_THUMB         = 8'd4;
  localparam gesture_t GEST_INDEX         = 8'd5;
  localparam gesture_t GEST_MIDDLE        = 8'd6;
  localparam gesture_t GEST_RING          = 8'd7;
  localparam gesture_t GEST_PINKY         = 8'd8;
  localparam gesture_t GEST_PINKY_PROMISE = 8'd9;
  localparam gesture_t GEST_ROCK_SIGN     = 8'd10;

  // Pattern bit order is {pinky, ring, middle, index, thumb}; 1 = flexed.
  function automatic gesture_t encode_pattern(input logic [NUM_FINGERS-1:0] pattern);
    gesture_t code;
    case (pattern)
      5'b11111: code = GEST_ROCK;
      5'b00000: code = GEST_PAPER;
      5'b11001: code = GEST_SCISSORS;
      5'b00001: code = GEST_THUMB;
      5'b00010: code = GEST_INDEX;
      5'b00100: code = GEST_MIDDLE;
      5'b01000: code = GEST_RING;
      5'b10000: code = GEST_PINKY;
      5'b01110: code = GEST_PINKY_PROMISE;
      5'b01100: code = GEST_ROCK_SIGN;
      default:  code = GEST_NONE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/gesture_encoder_pwm_capture.sv
// One servo-PWM channel: synchronizer, edge detect, pulse-width and timeout counters in 1 us ticks,
// plus fresh/stale flags.
module pwm_capture
  import gesture_pkg::*;
#(
  parameter int unsigned MIN_US     = 500,
  parameter int unsigned MAX_US     = 2500,
  parameter int unsigned TIMEOUT_US = 25000
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      tick_i,
  input  logic      pwm_i,
  input  logic      fresh_clr_i,
  output width_us_t width_o,
  output logic      fresh_o,
  output logic      stale_o
);

  localparam width_us_t MIN_W = width_us_t'(MIN_US);
  localparam width_us_t MAX_W = width_us_t'(MAX_US);
  localparam width_us_t SAT_W = width_us_t'(MAX_US + 1);
  localparam width_us_t TO_W  = width_us_t'(TIMEOUT_US);

  typedef enum logic {ST_WAIT_RISE, ST_HIGH} cap_state_e;

  cap_state_e state_q, state_d;
  logic [1:0] sync_q;
  logic       level_prev_q;
  width_us_t  cnt_q, cnt_d;
  width_us_t  to_q, to_d;
  width_us_t  width_q, width_d;
  width_us_t  cnt_inc_c;
  logic       fresh_q, fresh_d;
  logic       stale_q, stale_d;
  logic       rise_c, fall_c;

  assign rise_c    = sync_q[1] & ~level_prev_q;
  assign fall_c    = ~sync_q[1] & level_prev_q;
  assign cnt_inc_c = (tick_i && (cnt_q < SAT_W)) ? cnt_q + width_us_t'(1) : cnt_q;

  // Synchronizer resets to "high" so a pulse already in progress at reset is never seen as a rise.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q       <= 2'b11;
      level_prev_q <= 1'b1;
      state_q      <= ST_WAIT_RISE;
      cnt_q        <= '0;
      to_q         <= '0;
      width_q      <= '0;
      fresh_q      <= 1'b0;
      stale_q      <= 1'b1;
    end else begin
      sync_q       <= {sync_q[0], pwm_i};
      level_prev_q <= sync_q[1];
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      to_q         <= to_d;
      width_q      <= width_d;
      fresh_q      <= fresh_d;
      stale_q      <= stale_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    to_d    = to_q;
    width_d = width_q;
    fresh_d = fresh_q;
    stale_d = stale_q;

    if (fresh_clr_i) fresh_d = 1'b0;
    if (tick_i && (to_q < TO_W)) to_d = to_q + width_us_t'(1);

    case (state_q)
      ST_WAIT_RISE: begin
        if (rise_c) begin
          state_d = ST_HIGH;
          cnt_d   = '0;
          to_d    = '0;
        end
      end
      ST_HIGH: begin
        if (fall_c) begin
          state_d = ST_WAIT_RISE;
          if ((cnt_inc_c >= MIN_W) && (cnt_inc_c <= MAX_W)) begin
            width_d = cnt_inc_c;
            fresh_d = 1'b1;
            stale_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_inc_c;
        end
      end
      default: state_d = ST_WAIT_RISE;
    endcase

    // Timeout judged on the post-rise counter so a rise on the expiry cycle still restarts capture.
    if (to_d >= TO_W) begin
      stale_d = 1'b1;
      fresh_d = 1'b0;
      state_d = ST_WAIT_RISE;
    end
  end

  assign width_o = width_q;
  assign fresh_o = fresh_q;
  assign stale_o = stale_q;

endmodule

// File: rtl/gesture_encoder.sv
// Five-channel PWM measurement to 8-bit gesture code with frame stability filtering and stale handling.
// Optional hysteresis on the flex threshold is enabled by defining GESTURE_HYST_EN.
module gesture_encoder
  import gesture_pkg::*;
#(
  parameter int unsigned TICK_DIV      = 50,
  parameter int unsigned THRESH_US     = 1500,
  parameter int unsigned HYST_US       = 50,
  parameter int unsigned MIN_US        = 500,
  parameter int unsigned MAX_US        = 2500,
  parameter int unsigned TIMEOUT_US    = 25000,
  parameter int unsigned STABLE_FRAMES = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_FINGERS-1:0] pwm_in,
  output logic [GEST_W-1:0]      gesture,
  output logic                   gesture_valid,
  output logic [NUM_FINGERS-1:0] flexed,
  output logic [NUM_FINGERS-1:0] chan_stale
);

  if (TICK_DIV < 1) begin : g_bad_div
    $error("TICK_DIV must be at least 1");
  end
  if (STABLE_FRAMES < 1) begin : g_bad_stable
    $error("STABLE_FRAMES must be at least 1");
  end
  if (HYST_US >= THRESH_US) begin : g_bad_hyst
    $error("HYST_US must be below THRESH_US");
  end

  localparam int unsigned DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned CNT_W = (STABLE_FRAMES >= 1) ? $clog2(STABLE_FRAMES + 1) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_FRAMES);
`ifdef GESTURE_HYST_EN
  localparam width_us_t FLEX_ON_W  = width_us_t'(THRESH_US + HYST_US);
  localparam width_us_t FLEX_OFF_W = width_us_t'(THRESH_US - HYST_US);
`else
  localparam width_us_t THRESH_W   = width_us_t'(THRESH_US);
`endif

  logic [DIV_W-1:0]       div_q;
  logic                   tick_c;
  width_us_t              widths_c [NUM_FINGERS];
  logic [NUM_FINGERS-1:0] fresh_c, stale_c, flex_next_c;
  logic                   frame_c, any_stale_c, stale_rise_c;

  logic [NUM_FINGERS-1:0] flexed_q, flexed_d;
  logic [NUM_FINGERS-1:0] stale_prev_q, stale_prev_d;
  gesture_t               cand_q, cand_d;
  gesture_t               gesture_q, gesture_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   chk_q, chk_d;
  logic                   valid_q, valid_d;

  // Shared 1 us tick for all channels.
  assign tick_c = (div_q == DIV_LAST);
  always_ff @(posedge clk) begin
    if (reset) div_q <= '0;
    else       div_q <= tick_c ? '0 : div_q + DIV_W'(1);
  end

  for (genvar g = 0; g < NUM_FINGERS; g++) begin : g_cap
    pwm_capture #(
      .MIN_US     (MIN_US),
      .MAX_US     (MAX_US),
      .TIMEOUT_US (TIMEOUT_US)
    ) u_cap (
      .clk         (clk),
      .reset       (reset),
      .tick_i      (tick_c),
      .pwm_i       (pwm_in[g]),
      .fresh_clr_i (frame_c),
      .width_o     (widths_c[g]),
      .fresh_o     (fresh_c[g]),
      .stale_o     (stale_c[g])
    );
  end

  assign any_stale_c  = |stale_c;
  assign stale_rise_c = |(stale_c & ~stale_prev_q);
  assign frame_c      = (&fresh_c) & ~any_stale_c;

  always_comb begin
    flex_next_c = '0;
    for (int unsigned i = 0; i < NUM_FINGERS; i++) begin
`ifdef GESTURE_HYST_EN
      if (widths_c[i] >= FLEX_ON_W)       flex_next_c[i] = 1'b1;
      else if (widths_c[i] <= FLEX_OFF_W) flex_next_c[i] = 1'b0;
      else                                flex_next_c[i] = flexed_q[i];
`else
      flex_next_c[i] = (widths_c[i] >= THRESH_W);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flexed_q     <= '0;
      stale_prev_q <= '1;
      cand_q       <= GEST_NONE;
      gesture_q    <= GEST_NONE;
      count_q      <= '0;
      chk_q        <= 1'b0;
      valid_q      <= 1'b0;
    end else begin
      flexed_q     <= flexed_d;
      stale_prev_q <= stale_prev_d;
      cand_q       <= cand_d;
      gesture_q    <= gesture_d;
      count_q      <= count_d;
      chk_q        <= chk_d;
      valid_q      <= valid_d;
    end
  end

  // Frame at N classifies at N+1 and may commit at N+2; a newly stale channel overrides both.
  always_comb begin
    flexed_d     = flexed_q;
    stale_prev_d = stale_c;
    cand_d       = cand_q;
    gesture_d    = gesture_q;
    count_d      = count_q;
    chk_d        = 1'b0;
    valid_d      = 1'b0;

    if (stale_rise_c) begin
      gesture_d = GEST_NONE;
      valid_d   = (gesture_q != GEST_NONE);
      count_d   = '0;
    end else begin
      if (chk_q && !any_stale_c && (count_q >= CNT_MAX) && (cand_q != gesture_q)) begin
        gesture_d = cand_q;
        valid_d   = 1'b1;
      end
      if (frame_c) begin
        chk_d    = 1'b1;
        flexed_d = flex_next_c;
        cand_d   = encode_pattern(flex_next_c);
        if (cand_d == cand_q) count_d = (count_q >= CNT_MAX) ? CNT_MAX : count_q + CNT_W'(1);
        else                  count_d = CNT_W'(1);
      end
    end
  end

  assign gesture       = gesture_q;
  assign gesture_valid = valid_q;
  assign flexed        = flexed_q;
  assign chan_stale    = stale_c;

endmodule

// File: tb/tb_gesture_encoder.sv
// Directed bench for gesture_encoder with a 1-cycle us tick and a shortened channel timeout.
module tb_gesture_encoder;
  import gesture_pkg::*;

  localparam int unsigned TB_TIMEOUT = 5000;
  localparam int unsigned GAP        = 100;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] pwm_in;
  logic [7:0] gesture;
  logic       gesture_valid;
  logic [4:0] flexed;
  logic [4:0] chan_stale;

  int         n_cmp   = 0;
  int         n_bad   = 0;
  int         n_valid = 0;
  logic [7:0] last_code = 8'h00;
  int         v0;

  always #5 clk = ~clk;

  gesture_encoder #(
    .TICK_DIV   (1),
    .TIMEOUT_US (TB_TIMEOUT)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .pwm_in        (pwm_in),
    .gesture       (gesture),
    .gesture_valid (gesture_valid),
    .flexed        (flexed),
    .chan_stale    (chan_stale)
  );

  always @(posedge clk) begin
    if (gesture_valid) begin
      n_valid   = n_valid + 1;
      last_code = gesture;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (got !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // One PWM frame: masked channels start together, each stays high w[i] cycles, then idle gap.
  task automatic run_frame(input int unsigned w0, input int unsigned w1, input int unsigned w2,
                           input int unsigned w3, input int unsigned w4, input logic [4:0] mask);
    int unsigned w[5];
    int unsigned wmax;
    w    = '{w0, w1, w2, w3, w4};
    wmax = 0;
    for (int i = 0; i < 5; i++) if (mask[i] && w[i] > wmax) wmax = w[i];
    @(negedge clk);
    pwm_in = mask;
    for (int unsigned c = 1; c <= wmax; c++) begin
      @(negedge clk);
      for (int i = 0; i < 5; i++) if (c >= w[i]) pwm_in[i] = 1'b0;
    end
    pwm_in = '0;
    repeat (GAP) @(negedge clk);
  endtask

  initial begin
    #(10 * 150000);
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset  = 1'b1;
    pwm_in = '0;
    repeat (5) @(negedge clk);
    reset = 1'b0;

    // No PWM activity for longer than the timeout.
    repeat (TB_TIMEOUT + 100) @(negedge clk);
    check_eq("idle_stale",   32'(chan_stale), 32'h1F);
    check_eq("idle_gesture", 32'(gesture),    32'd0);
    check_eq("idle_flexed",  32'(flexed),     32'd0);
    check_eq("idle_nvalid",  32'(n_valid),    32'd0);

    // Rock: all flexed, commits only after the third frame.
    v0 = n_valid;
    run_frame(1950, 1950, 1950, 1950, 1950, 5'h1F);
    check_eq("rock_f1_flexed", 32'(flexed),     32'h1F);
    check_eq("rock_f1_stale",  32'(chan_stale), 32'h00);
    run_frame(1950, 1950, 1950, 1950, 1950, 5'h1F);
    check_eq("rock_f2_gesture", 32'(gesture), 32'd0);
    run_frame(1950, 1950, 1950, 1950, 1950, 5'h1F);
    check_eq("rock_f3_gesture", 32'(gesture),      32'd1);
    check_eq("rock_nvalid",     32'(n_valid - v0), 32'd1);
    check_eq("rock_valid_code", 32'(last_code),    32'd1);

    // Paper: two frames are not enough, the third commits.
    v0 = n_valid;
    run_frame(1000, 1100, 1000, 1000, 1300, 5'h1F);
    run_frame(1000, 1100, 1000, 1000, 1300, 5'h1F);
    check_eq("paper_f2_gesture", 32'(gesture),      32'd1);
    check_eq("paper_f2_nvalid",  32'(n_valid - v0), 32'd0);
    run_frame(1000, 1100, 1000, 1000, 1300, 5'h1F);
    check_eq("paper_f3_gesture", 32'(gesture),      32'd2);
    check_eq("paper_nvalid",     32'(n_valid - v0), 32'd1);

    // Scissors, then an unmapped pattern 10101 drives the code to 0.
    v0 = n_valid;
    for (int f = 0; f < 3; f++) run_frame(1900, 1100, 1000, 2000, 2000, 5'h1F);
    check_eq("sciss_flexed",  32'(flexed),      32'h19);
    check_eq("sciss_gesture", 32'(gesture),     32'd3);
    check_eq("sciss_nvalid",  32'(n_valid - v0), 32'd1);
    v0 = n_valid;
    for (int f = 0; f < 3; f++) run_frame(1900, 1000, 1900, 1000, 1900, 5'h1F);
    check_eq("other_flexed",  32'(flexed),      32'h15);
    check_eq("other_gesture", 32'(gesture),     32'd0);
    check_eq("other_nvalid",  32'(n_valid - v0), 32'd1);
    check_eq("other_code",    32'(last_code),   32'd0);

    // Thumb threshold behaviour.
    run_frame(1600, 1000, 1000, 1000, 1000, 5'h1F);
    check_eq("thr_1600", 32'(flexed[0]), 32'd1);
    run_frame(1520, 1000, 1000, 1000, 1000, 5'h1F);
    check_eq("thr_1520", 32'(flexed[0]), 32'd1);
    run_frame(1490, 1000, 1000, 1000, 1000, 5'h1F);
`ifdef GESTURE_HYST_EN
    check_eq("thr_1490", 32'(flexed[0]), 32'd1);
`else
    check_eq("thr_1490", 32'(flexed[0]), 32'd0);
`endif
    run_frame(1440, 1000, 1000, 1000, 1000, 5'h1F);
    check_eq("thr_1440", 32'(flexed[0]), 32'd0);

    // Back to rock, then lose the index channel.
    for (int f = 0; f < 3; f++) run_frame(1950, 1950, 1950, 1950, 1950, 5'h1F);
    check_eq("rock2_gesture", 32'(gesture), 32'd1);
    v0 = n_valid;
    for (int f = 0; f < 3; f++) run_frame(1950, 1950, 1950, 1950, 1950, 5'h1D);
    check_eq("lost_stale",   32'(chan_stale),   32'h02);
    check_eq("lost_gesture", 32'(gesture),      32'd0);
    check_eq("lost_nvalid",  32'(n_valid - v0), 32'd1);
    check_eq("lost_code",    32'(last_code),    32'd0);

    // Out-of-range index pulses are discarded: channel stays stale, nothing commits.
    v0 = n_valid;
    run_frame(1950, 400, 1950, 1950, 1950, 5'h1F);
    check_eq("short_stale", 32'(chan_stale), 32'h02);
    run_frame(1950, 2600, 1950, 1950, 1950, 5'h1F);
    check_eq("long_stale",   32'(chan_stale),   32'h02);
    check_eq("long_gesture", 32'(gesture),      32'd0);
    check_eq("long_nvalid",  32'(n_valid - v0), 32'd0);

    // Recovery once the index channel returns valid pulses.
    for (int f = 0; f < 3; f++) run_frame(1950, 1950, 1950, 1950, 1950, 5'h1F);
    check_eq("recov_stale",   32'(chan_stale),   32'h00);
    check_eq("recov_gesture", 32'(gesture),      32'd1);
    check_eq("recov_nvalid",  32'(n_valid - v0), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
